da_sequencer: RTL and testbench

Control and sample-staging block for the distributed-arithmetic FIR datapath. It accepts input samples over a valid/ready handshake and holds them in a 32-tap delay line. For each sample it walks the 16 bit-slices MSB-first, driving the 8 LUT address nibbles and the accumulator controls (enable, clear, sign-subtract). It then captures the finished sum into a one-deep result slot with its own valid/ready handshake. It replaces the free-running counter/enable scheme around the shift-accumulate adder tree.

---
 rtl/da_sequencer.sv | 133 +++++++++++++
 tb/tb_da_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_sequencer.sv
// Sequencer for a bit-serial distributed-arithmetic FIR. It stages samples in a
// tap delay line, walks the bit-slices MSB-first and hands each result to a one-deep slot.
module da_sequencer #(
  parameter int NUM_LUTS     = 8,
  parameter int TAPS_PER_LUT = 4,
  parameter int DATA_W       = 16
) (
  input  logic                             clk3,
  input  logic                             reset,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_LUTS*TAPS_PER_LUT-1:0] lut_addr,
  output logic                             acc_en,
  output logic                             acc_clear,
  output logic                             acc_sub,
  output logic                             capture,
  output logic                             sum_valid,
  input  logic                             sum_ready,
  output logic                             busy
);

  localparam int NTAPS = NUM_LUTS * TAPS_PER_LUT;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLICE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt_next;
  logic [DATA_W-1:0]  tap_reg [NTAPS];
  logic               sum_valid_reg;
  logic               sum_valid_next;
  logic               accept;
  logic               slice_live;

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      sum_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      sum_valid_reg <= sum_valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    accept       = 1'b0;
    slice_live   = 1'b0;
    acc_en       = 1'b0;
    acc_clear    = 1'b0;
    acc_sub      = 1'b0;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept       = 1'b1;
          bit_cnt_next = CNT_MSB;
          state_next   = SLICE;
        end
      end
      SLICE: begin
        slice_live = 1'b1;
        acc_en     = 1'b1;
        // The sign-bit slice comes first: it seeds the accumulator and is subtracted.
        if (bit_cnt_reg == CNT_MSB) begin
          acc_clear = 1'b1;
          acc_sub   = 1'b1;
        end
        if (bit_cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      DONE: begin
        // The slot is free when empty or being drained in this same cycle.
        if (!sum_valid_reg || sum_ready) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    sum_valid_next = sum_valid_reg;
    if (capture) begin
      sum_valid_next = 1'b1;
    end else if (sum_valid_reg && sum_ready) begin
      sum_valid_next = 1'b0;
    end
  end

  // Delay line only moves on accept, so it stays frozen through slicing and stalls.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        tap_reg[i] <= '0;
      end
    end else if (accept) begin
      tap_reg[0] <= in_data;
      for (int i = 1; i < NTAPS; i++) begin
        tap_reg[i] <= tap_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_addr
      assign lut_addr[gi] = slice_live & tap_reg[gi][bit_cnt_reg];
    end
  endgenerate

  assign in_ready  = reset & (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign sum_valid = sum_valid_reg;

endmodule

// File: tb/tb_da_sequencer.sv
// Bench for da_sequencer: a tap-line model predicts every slice address and
// handshake output, with random samples, gaps and result-slot stalls.
module tb_da_sequencer;

  localparam int NL = 8;
  localparam int TL = 4;
  localparam int DW = 16;
  localparam int NT = NL * TL;

  logic          clk3 = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NT-1:0] lut_addr;
  logic          acc_en;
  logic          acc_clear;
  logic          acc_sub;
  logic          capture;
  logic          sum_valid;
  logic          sum_ready;
  logic          busy;

  da_sequencer #(.NUM_LUTS(NL), .TAPS_PER_LUT(TL), .DATA_W(DW)) dut (
    .clk3(clk3), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .lut_addr(lut_addr), .acc_en(acc_en),
    .acc_clear(acc_clear), .acc_sub(acc_sub), .capture(capture),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
  );

  always #5 clk3 = ~clk3;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  always @(posedge clk3) cycle_cnt++;

  // Reference model: the tap line as a plain array plus the result-slot flag.
  logic [DW-1:0] line [NT];
  logic          mdl_sv;
  logic [NT-1:0] last_addr [DW];
  int            last_accept;
  int            last_capture;

  function automatic logic [NT-1:0] exp_addr(input int b);
    logic [NT-1:0] r;
    for (int i = 0; i < NT; i++) r[i] = line[i][b];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) line[i] = '0;
    mdl_sv = 1'b0;
  endtask

  task automatic model_accept(input logic [DW-1:0] s);
    for (int i = NT - 1; i > 0; i--) line[i] = line[i-1];
    line[0] = s;
  endtask

  task automatic step();
    @(posedge clk3);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  // One full sample: accept, 16 slices, DONE with 'stall' cycles of sum_ready=0.
  task automatic do_pass(input logic [DW-1:0] s, input int stall);
    logic [NT-1:0] ea;
    logic          first;
    logic          exp_cap;
    in_data = s;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    model_accept(s);
    if (sum_ready) mdl_sv = 1'b0;
    step();
    last_accept = cycle_cnt;
    in_valid = 1'b0;
    in_data = DW'($urandom);
    for (int k = 0; k < DW; k++) begin
      int b;
      b = DW - 1 - k;
      ea = exp_addr(b);
      first = (b == DW - 1);
      last_addr[b] = lut_addr;
      checks++;
      if (lut_addr !== ea || acc_en !== 1'b1 || acc_clear !== first || acc_sub !== first ||
          capture !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || sum_valid !== mdl_sv) begin
        errors++;
        $display("FAIL slice b=%0d: addr=%h en=%b clr=%b sub=%b cap=%b rdy=%b busy=%b sv=%b, required addr=%h en=1 clr=%b sub=%b cap=0 rdy=0 busy=1 sv=%b",
                 b, lut_addr, acc_en, acc_clear, acc_sub, capture, in_ready, busy, sum_valid,
                 ea, first, first, mdl_sv);
      end
      if (sum_ready) mdl_sv = 1'b0;
      step();
    end
    for (int n = 0; n <= stall + 1; n++) begin
      sum_ready = (n < stall) ? 1'b0 : 1'b1;
      #1;
      exp_cap = !mdl_sv || sum_ready;
      checks++;
      if (capture !== exp_cap || acc_en !== 1'b0 || lut_addr !== '0 || acc_clear !== 1'b0 ||
          acc_sub !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL done n=%0d: cap=%b en=%b addr=%h clr=%b sub=%b rdy=%b busy=%b, required cap=%b en=0 addr=0 clr=0 sub=0 rdy=0 busy=1",
                 n, capture, acc_en, lut_addr, acc_clear, acc_sub, in_ready, busy, exp_cap);
      end
      if (exp_cap) break;
      step();
    end
    last_capture = cycle_cnt;
    step();
    mdl_sv = 1'b1;
    checks++;
    if (sum_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_capture: sv=%b busy=%b rdy=%b, required 1 0 1", sum_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    sum_ready = 1'b0;
    model_reset();
    #3;
    checks++;
    if (in_ready !== 1'b0 || sum_valid !== 1'b0 || lut_addr !== '0 || busy !== 1'b0 ||
        acc_en !== 1'b0 || capture !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: rdy=%b sv=%b addr=%h busy=%b en=%b cap=%b, required all 0",
               in_ready, sum_valid, lut_addr, busy, acc_en, capture);
    end
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0 || lut_addr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: rdy=%b sv=%b addr=%h busy=%b, required 1 0 0 0",
               in_ready, sum_valid, lut_addr, busy);
    end
    step();
    // Taps must read back as zero: the lone sample is the only non-zero tap.
    sum_ready = 1'b1;
    do_pass(16'h0001, 0);
    checks++;
    if (last_addr[0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_taps: bit0 addr=%h, required 00000001", last_addr[0]);
    end
  endtask

  task automatic test_single();
    logic [NT-1:0] mid;
    apply_reset();
    step();
    sum_ready = 1'b1;
    do_pass(16'h8001, 0);
    mid = '0;
    for (int b = 1; b < DW - 1; b++) mid |= last_addr[b];
    checks++;
    if (last_addr[15] !== 32'h1 || last_addr[0] !== 32'h1 || mid !== '0) begin
      errors++;
      $display("FAIL single_addr: b15=%h b0=%h mid=%h, required 1 1 0", last_addr[15], last_addr[0], mid);
    end
    checks++;
    if (last_capture - last_accept != 16) begin
      errors++;
      $display("FAIL single_capture_time: %0d cycles after accept edge, required 16", last_capture - last_accept);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    apply_reset();
    step();
    sum_ready = 1'b1;
    do_pass(16'hFFFF, 0);
    t1 = last_accept;
    do_pass(16'h0001, 0);
    checks++;
    if (last_accept - t1 != 18) begin
      errors++;
      $display("FAIL b2b_period: %0d cycles between accepts, required 18", last_accept - t1);
    end
    checks++;
    if (last_addr[15] !== 32'h2 || last_addr[0] !== 32'h3) begin
      errors++;
      $display("FAIL b2b_addr: b15=%h b0=%h, required 2 3", last_addr[15], last_addr[0]);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step();
    sum_ready = 1'b1;
    do_pass(16'($urandom), 0);
    sum_ready = 1'b0;
    do_pass(16'($urandom), 3);
    checks++;
    if (last_capture - last_accept != 19) begin
      errors++;
      $display("FAIL stall_capture_time: %0d cycles after accept edge, required 19", last_capture - last_accept);
    end
    sum_ready = 1'b1;
    step();
    mdl_sv = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL consume: sv=%b busy=%b, required 0 0", sum_valid, busy);
    end
  endtask

  task automatic test_wrap();
    logic [NT-1:0] all;
    apply_reset();
    step();
    sum_ready = 1'b1;
    do_pass(16'h0001, 0);
    for (int p = 2; p <= NT; p++) do_pass(16'h0000, 0);
    checks++;
    if (last_addr[0] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL wrap_tap31: bit0 addr=%h, required 80000000", last_addr[0]);
    end
    do_pass(16'h0000, 0);
    all = '0;
    for (int b = 0; b < DW; b++) all |= last_addr[b];
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL wrap_gone: or of addrs=%h, required 0", all);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step();
    sum_ready = 1'b1;
    in_data = 16'hFFFF;
    in_valid = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (acc_en !== 1'b0 || lut_addr !== '0 || capture !== 1'b0 || sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: en=%b addr=%h cap=%b sv=%b busy=%b, required all 0",
               acc_en, lut_addr, capture, sum_valid, busy);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (capture !== 1'b0 || sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: cap=%b sv=%b, required 0 0", capture, sum_valid);
      end
    end
    reset = 1'b1;
    model_reset();
    do_pass(16'h0001, 0);
    checks++;
    if (last_addr[15] !== '0 || last_addr[0] !== 32'h1) begin
      errors++;
      $display("FAIL reset_mid_restart: b15=%h b0=%h, required 0 1", last_addr[15], last_addr[0]);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 14; p++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data = DW'($urandom);
        sum_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || lut_addr !== '0 || acc_en !== 1'b0 ||
            capture !== 1'b0 || sum_valid !== mdl_sv) begin
          errors++;
          $display("FAIL idle_gap: rdy=%b busy=%b addr=%h en=%b cap=%b sv=%b, required 1 0 0 0 0 %b",
                   in_ready, busy, lut_addr, acc_en, capture, sum_valid, mdl_sv);
        end
        if (sum_ready) mdl_sv = 1'b0;
        step();
      end
      sum_ready = 1'($urandom_range(0, 1));
      do_pass(DW'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
